collision_game_state: RTL and testbench

- Sits downstream of the per-sprite renderers (player, glaciers, goal).
- Consumes their per-pixel hit flags during scan-out and counts player/obstacle overlap pixels per frame.
- At each frame boundary, decides hits, lives, death and level completion.
- Drives the is_dead / is_finished flags back into every sprite's motion logic, and a frame timer for the HUD.

---
 rtl/game_pkg.sv | 20 ++
 rtl/vsync_edge.sv | 19 +
 rtl/collision_game_state.sv | 149 ++++++++++++++
 tb/tb_collision_game_state.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the collision/game-state logic and the sprite blocks.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        INVULN   = 2'd1,
        DEAD     = 2'd2,
        FINISHED = 2'd3
    } game_state_e;

    localparam int DEF_LIVES         = 3;
    localparam int DEF_HIT_THRESHOLD = 16;
    localparam int DEF_INVULN_FRAMES = 60;
    localparam int FRAME_CNT_W       = 16;

    function automatic logic [FRAME_CNT_W-1:0] frame_sat_inc(input logic [FRAME_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vsync_edge.sv
// Registers v_sync and produces a one-cycle frame_tick on its rising edge.
module vsync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_v_sync,
    output logic o_frame_tick
);

    logic v_sync_q;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) v_sync_q <= 1'b0;
        else       v_sync_q <= i_v_sync;
    end

    assign o_frame_tick = i_v_sync & ~v_sync_q;

endmodule

// File: rtl/collision_game_state.sv
// Per-frame collision accounting, lives and PLAY/INVULN/DEAD/FINISHED state.
// Optional player blink output enabled by defining COLLISION_HIT_FLASH_EN.
module collision_game_state
    import game_pkg::*;
#(
    parameter int N_OBST        = 4,
    parameter int LIVES         = DEF_LIVES,
    parameter int HIT_THRESHOLD = DEF_HIT_THRESHOLD,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int CNT_W         = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_v_sync,
    input  logic                   i_player_hit,
    input  logic [N_OBST-1:0]      i_obstacle_hit,
    input  logic                   i_goal_hit,
    input  logic                   i_restart,
    output logic                   o_is_dead,
    output logic                   o_is_finished,
    output logic [3:0]             o_lives,
    output logic [1:0]             o_state,
    output logic [FRAME_CNT_W-1:0] o_frame_count,
    output logic                   o_flash
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic frame_tick;
    logic overlap;
    logic goal_px;
    logic hit;

    game_state_e            state_q;
    logic [3:0]             lives_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   goal_seen_q, goal_seen_d;
    logic [7:0]             invuln_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   is_dead_q;
    logic                   is_finished_q;

    vsync_edge u_vsync_edge (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_v_sync     (i_v_sync),
        .o_frame_tick (frame_tick)
    );

    assign overlap = i_player_hit & (|i_obstacle_hit);
    assign goal_px = i_player_hit & i_goal_hit;
    assign hit     = (cnt_q >= CNT_W'(HIT_THRESHOLD));

    // The tick cycle's own pixel seeds the next frame; evaluation uses the pre-tick values.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        cnt_d       = cnt_q;
        goal_seen_d = goal_seen_q;
        if (i_restart) begin
            cnt_d       = '0;
            goal_seen_d = 1'b0;
        end else if (frame_tick) begin
            cnt_d       = CNT_W'(overlap);
            goal_seen_d = goal_px;
        end else begin
            if (overlap && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
            if (goal_px) goal_seen_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= PLAY;
            lives_q       <= 4'(LIVES);
            cnt_q         <= '0;
            goal_seen_q   <= 1'b0;
            invuln_q      <= '0;
            frame_cnt_q   <= '0;
            is_dead_q     <= 1'b0;
            is_finished_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            goal_seen_q <= goal_seen_d;
            if (i_restart) begin
                state_q       <= PLAY;
                lives_q       <= 4'(LIVES);
                invuln_q      <= '0;
                frame_cnt_q   <= '0;
                is_dead_q     <= 1'b0;
                is_finished_q <= 1'b0;
            end else if (frame_tick) begin
                case (state_q)
                    PLAY: begin
                        frame_cnt_q <= frame_sat_inc(frame_cnt_q);
                        if (goal_seen_q) begin
                            state_q       <= FINISHED;
                            is_finished_q <= 1'b1;
                        end else if (hit) begin
                            if (lives_q == 4'd1) begin
                                lives_q   <= 4'd0;
                                state_q   <= DEAD;
                                is_dead_q <= 1'b1;
                            end else begin
                                lives_q  <= lives_q - 4'd1;
                                state_q  <= INVULN;
                                invuln_q <= 8'(INVULN_FRAMES - 1);
                            end
                        end
                    end
                    INVULN: begin
                        frame_cnt_q <= frame_sat_inc(frame_cnt_q);
                        if (goal_seen_q) begin
                            state_q       <= FINISHED;
                            is_finished_q <= 1'b1;
                        end else if (invuln_q == 8'd0) begin
                            state_q <= PLAY;
                        end else begin
                            invuln_q <= invuln_q - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef COLLISION_HIT_FLASH_EN
    logic [2:0] flash_cnt_q;

    // Held at zero outside INVULN, so it starts from zero on every entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                   flash_cnt_q <= '0;
        else if (i_restart)          flash_cnt_q <= '0;
        else if (state_q != INVULN)  flash_cnt_q <= '0;
        else if (frame_tick)         flash_cnt_q <= flash_cnt_q + 3'd1;
    end

    assign o_flash = (state_q == INVULN) & flash_cnt_q[2];
`else
    assign o_flash = 1'b0;
`endif

    assign o_is_dead     = is_dead_q;
    assign o_is_finished = is_finished_q;
    assign o_lives       = lives_q;
    assign o_state       = state_q;
    assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_collision_game_state.sv
// Randomised scoreboard bench for collision_game_state against a frame-level game model.
module tb_collision_game_state;

    localparam int N_OBST  = 4;
    localparam int LIVES   = 3;
    localparam int THRESH  = 16;
    localparam int INV_FR  = 60;
    localparam int CNT_MAX = 4095;

    localparam int S_PLAY = 0, S_INVULN = 1, S_DEAD = 2, S_FIN = 3;

    typedef struct packed {
        logic        dead;
        logic        fin;
        logic [3:0]  lives;
        logic [1:0]  state;
        logic [15:0] fc;
        logic        flash;
    } out_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              v_sync;
    logic              player_hit;
    logic [N_OBST-1:0] obstacle_hit;
    logic              goal_hit;
    logic              restart;
    logic              is_dead;
    logic              is_finished;
    logic [3:0]        lives;
    logic [1:0]        state;
    logic [15:0]       frame_count;
    logic              flash;

    collision_game_state #(
        .N_OBST        (N_OBST),
        .LIVES         (LIVES),
        .HIT_THRESHOLD (THRESH),
        .INVULN_FRAMES (INV_FR),
        .CNT_W         (12)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_v_sync       (v_sync),
        .i_player_hit   (player_hit),
        .i_obstacle_hit (obstacle_hit),
        .i_goal_hit     (goal_hit),
        .i_restart      (restart),
        .o_is_dead      (is_dead),
        .o_is_finished  (is_finished),
        .o_lives        (lives),
        .o_state        (state),
        .o_frame_count  (frame_count),
        .o_flash        (flash)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    out_t exp_q[$];
    bit   rst_on;
    bit   seed_rand;

    // Game model: tracks frames, lives and how many frames have passed since the last hit.
    int m_state, m_lives, m_cnt, m_fc, m_inv_frames;
    bit m_goal, m_vs_prev;

    function automatic void model_reset();
        m_state = S_PLAY; m_lives = LIVES; m_cnt = 0; m_goal = 0;
        m_fc = 0; m_inv_frames = 0; m_vs_prev = 0;
    endfunction

    function automatic void model_step(bit vs, bit ov, bit gp, bit rs);
        bit tick;
        tick = vs && !m_vs_prev;
        m_vs_prev = vs;
        if (rs) begin
            m_state = S_PLAY; m_lives = LIVES; m_cnt = 0; m_goal = 0;
            m_fc = 0; m_inv_frames = 0;
        end else if (tick) begin
            if (m_state == S_PLAY || m_state == S_INVULN)
                m_fc = (m_fc == 65535) ? 65535 : m_fc + 1;
            if (m_state == S_PLAY) begin
                if (m_goal) m_state = S_FIN;
                else if (m_cnt >= THRESH) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_state = S_DEAD;
                    else begin m_state = S_INVULN; m_inv_frames = 0; end
                end
            end else if (m_state == S_INVULN) begin
                m_inv_frames = m_inv_frames + 1;
                if (m_goal) m_state = S_FIN;
                else if (m_inv_frames == INV_FR) m_state = S_PLAY;
            end
            m_cnt = ov ? 1 : 0;
            m_goal = gp;
        end else begin
            if (ov && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (gp) m_goal = 1;
        end
    endfunction

    function automatic out_t model_out();
        out_t o;
        o.dead  = (m_state == S_DEAD);
        o.fin   = (m_state == S_FIN);
        o.lives = 4'(m_lives);
        o.state = 2'(m_state);
        o.fc    = 16'(m_fc);
`ifdef COLLISION_HIT_FLASH_EN
        o.flash = (m_state == S_INVULN) && ((m_inv_frames % 8) >= 4);
`else
        o.flash = 1'b0;
`endif
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.dead = is_dead; o.fin = is_finished; o.lives = lives;
        o.state = state; o.fc = frame_count; o.flash = flash;
        return o;
    endfunction

    task automatic check(input string name, input out_t got, input out_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got dead=%0d fin=%0d lives=%0d state=%0d fc=%0d flash=%0d, required dead=%0d fin=%0d lives=%0d state=%0d fc=%0d flash=%0d",
                     name, $time, got.dead, got.fin, got.lives, got.state, got.fc, got.flash,
                     want.dead, want.fin, want.lives, want.state, want.fc, want.flash);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, required %0d", name, $time, got, want);
        end
    endtask

    // Monitor: every registered output update is compared half a cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check("cycle", dut_out(), exp_q.pop_front());
        end
    end

    task automatic drive_cycle(input bit vs, input bit p, input logic [N_OBST-1:0] o,
                               input bit g, input bit rs);
        rst = rst_on; v_sync = vs; player_hit = p; obstacle_hit = o; goal_hit = g; restart = rs;
        @(posedge clk);
        if (rst_on) model_reset();
        else        model_step(vs, p && (o != '0), p && g, rs);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic frame(input int n_pix, input int n_ov, input bit goal);
        logic              p, g;
        logic [N_OBST-1:0] o;
        for (int i = 0; i < n_pix; i++) begin
            if (i < n_ov) begin
                p = 1'b1; g = 1'b0; o = N_OBST'($urandom_range(1, (1 << N_OBST) - 1));
            end else if (goal && i == n_pix - 1) begin
                p = 1'b1; g = 1'b1; o = '0;
            end else if ($urandom_range(0, 1) == 1) begin
                p = 1'b1; g = 1'b0; o = '0;
            end else begin
                p = 1'b0; g = 1'($urandom); o = N_OBST'($urandom);
            end
            drive_cycle(1'b0, p, o, g, 1'b0);
        end
        if (seed_rand) drive_cycle(1'b1, 1'($urandom), N_OBST'($urandom), 1'($urandom), 1'b0);
        else           drive_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    out_t rst_vals;

    initial begin
        rst_vals = '{dead: 1'b0, fin: 1'b0, lives: 4'd3, state: 2'd0, fc: 16'd0, flash: 1'b0};
        rst = 1'b1; rst_on = 1'b1; seed_rand = 1'b0;
        v_sync = 1'b0; player_hit = 1'b0; obstacle_hit = '0; goal_hit = 1'b0; restart = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", dut_out(), rst_vals);
        rst_on = 1'b0;

        // Three quiet frames
        repeat (3) frame(40, 0, 1'b0);
        check_val("quiet_fc", frame_count, 3);
        check_val("quiet_lives", lives, 3);
        check_val("quiet_state", state, S_PLAY);
        check_val("quiet_dead", is_dead, 0);

        // Threshold boundary
        frame(40, 15, 1'b0);
        check_val("below_thresh_lives", lives, 3);
        frame(40, 16, 1'b0);
        check_val("at_thresh_lives", lives, 2);
        check_val("at_thresh_state", state, S_INVULN);

        // Invulnerability window ignores heavy overlap
        repeat (59) frame(120, 100, 1'b0);
        check_val("invuln_59_state", state, S_INVULN);
        frame(120, 100, 1'b0);
        check_val("invuln_60_state", state, S_PLAY);
        check_val("invuln_lives", lives, 2);
        frame(40, 16, 1'b0);
        check_val("second_hit_lives", lives, 1);

        // Third hit kills; frame count freezes
        repeat (60) frame(30, 0, 1'b0);
        frame(40, 16, 1'b0);
        check_val("dead_lives", lives, 0);
        check_val("dead_flag", is_dead, 1);
        check_val("dead_fc", frame_count, 127);
        repeat (3) frame(30, 20, 1'b0);
        check_val("dead_fc_frozen", frame_count, 127);

        // Restart coincident with a frame tick while dead
        drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check_val("restart_state", state, S_PLAY);
        check_val("restart_lives", lives, 3);
        check_val("restart_fc", frame_count, 0);

        // Goal beats collision in the same frame
        frame(60, 20, 1'b1);
        check_val("goal_state", state, S_FIN);
        check_val("goal_fin", is_finished, 1);
        check_val("goal_lives", lives, 3);
        repeat (2) frame(30, 0, 1'b0);
        check_val("fin_fc_frozen", frame_count, 1);

        // Randomised play with seeding tick pixels, saturation and restarts
        drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        seed_rand = 1'b1;
        frame(4200, 4150, 1'b0);
        for (int f = 0; f < 200; f++) begin
            int nov;
            nov = $urandom_range(0, 24);
            frame(nov + $urandom_range(2, 30), nov, $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0 ||
                ((m_state == S_DEAD || m_state == S_FIN) && $urandom_range(0, 2) == 0))
                drive_cycle(1'b0, 1'($urandom), N_OBST'($urandom), 1'($urandom), 1'b1);
        end

        // Asynchronous reset mid-frame with v_sync high at release
        seed_rand = 1'b0;
        frame(40, 16, 1'b0);
        repeat (5) drive_cycle(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        v_sync = 1'b1; rst = 1'b1; rst_on = 1'b1;
        #1;
        check("async_reset", dut_out(), rst_vals);
        model_reset();
        drive_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        rst_on = 1'b0;
        drive_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_val("tick_at_release_fc", frame_count, 1);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
